serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle bit-serial subtractor for the multi-cycle CPU datapath: computes
//  diff = a - b - bin one bit per clock, LSB first, using one 1-bit full
//  subtractor cell and a borrow flop. This is the inverse of the ripple adder
//  path. It serves SUB/SBC/CMP when area matters more than latency.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range 2..64
// PORTS
//  clk      in   1      clock; all state updates on rising edge
//  rst      in   1      asynchronous, active-high reset
//  start    in   1      request; sampled only in IDLE or DONE
//  a        in   WIDTH  minuend; captured on the accepted start edge
//  b        in   WIDTH  subtrahend; captured on the accepted start edge
//  bin      in   1      borrow-in; captured on the accepted start edge
//  busy     out  1      high while in RUN
//  done     out  1      one-cycle pulse: diff/bout are valid
//  diff     out  WIDTH  result; held stable from done until the next accepted start
//  bout     out  1      borrow-out from the MSB (1 = unsigned a < b + bin)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, busy=0, done=0, diff=0, bout=0, count=0.
//  - FSM: IDLE -start-> RUN; RUN -(count==WIDTH-1)-> DONE; DONE -start-> RUN; DONE -!start-> IDLE.
//  - Accepted start: shift regs <= a,b; borrow <= bin; count <= 0. start during RUN is ignored.
//  - RUN, each edge: bit d = a0^b0^br; br' = (~a0&b0)|(~(a0^b0)&br);
//    d shifts into diff from the MSB side; a/b shift right; count++.
//  - Latency: start accepted at edge 0; done=1 in the cycle after edge WIDTH
//    (WIDTH+1 cycles from start to done). bout <= final borrow on edge WIDTH.
//  - busy and done are never high together. done lasts exactly one cycle.
//  - start in DONE restarts at once (back-to-back throughput = WIDTH+1 cycles).
//  - diff does not change during RUN until the last edge; the result loads
//    from an internal shift register on that edge.
//  - Reset during RUN aborts: outputs return to reset values, no done pulse.
//  - Arithmetic is modulo 2^WIDTH; a==b with bin=0 gives diff=0, bout=0.
// CONFIGURATION
//  SERIAL_SUB_FLAGS_EN defined: adds outputs zero(1), neg(1), ovf(1). They are
//    valid with done, held with diff, and reset to 0.
//    zero = (diff==0); neg = diff[WIDTH-1]; ovf = signed overflow = a_msb^b_msb & a_msb^diff_msb.
//  Undefined: these ports and their logic are absent; all other behaviour is the same.
// STRUCTURE
//  - Shared package/header cpu_alu_defs: FSM state encoding (IDLE=2'd0,
//    RUN=2'd1, DONE=2'd2) and the count width macro (clog2 of WIDTH).
//  - One sub-module: full_subtractor (a, b, bin -> d, bout), gate-level, same
//    style as the full adder cell; instantiated once.
// TESTING
//  1. a=10,b=3,bin=0 -> done at cycle WIDTH+1; diff=7, bout=0; busy high for WIDTH cycles.
//  2. a=0,b=1,bin=0 -> diff=32'hFFFFFFFF, bout=1 (flags: neg=1, zero=0, ovf=0).
//  3. a=32'h80000000,b=1 -> diff=32'h7FFFFFFF, bout=0, ovf=1; a=5,b=5 -> diff=0, zero=1.
//  4. a=5,b=5,bin=1 -> diff=32'hFFFFFFFF, bout=1; a=0,b=0,bin=1 -> all-ones, bout=1.
//  5. start pulsed mid-RUN with new operands -> ignored; result is from the first operands.
//    start held high in DONE -> second result after a further WIDTH+1 cycles.
//  6. rst asserted at count=WIDTH/2 -> outputs zero immediately, no done;
//    a fresh start afterwards gives the correct result.
//  Also: randomized a,b,bin over 1000 ops against a reference model; WIDTH=2 and WIDTH=64 builds.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_pkg
//  Brief    : Shared definitions for the bit-serial subtractor: FSM state
//             encoding and the iteration-counter width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  // FSM state encoding shared with the rest of the ALU datapath
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the bit counter that walks 0..width-1 (at least one bit)
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor
//  Brief    : Gate-level 1-bit full subtractor cell.
//             d = a ^ b ^ bin ; bout = (~a & b) | (~(a ^ b) & bin)
//  Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  wire a_xor_b;
  wire a_n;
  wire xnor_ab;
  wire brw_gen;
  wire brw_prop;

  xor g_xor0 (a_xor_b, a, b);
  xor g_xor1 (d, a_xor_b, bin);
  not g_not0 (a_n, a);
  and g_and0 (brw_gen, a_n, b);
  not g_not1 (xnor_ab, a_xor_b);
  and g_and1 (brw_prop, xnor_ab, bin);
  or  g_or0  (bout, brw_gen, brw_prop);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : Bit-serial subtractor, diff = a - b - bin, one bit per clock,
//             LSB first, using a single full_subtractor cell and a borrow flop.
//             Optional macro SERIAL_SUB_FLAGS_EN adds zero/neg/ovf flags.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int            CW   = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  // a_sh doubles as the result shift register: difference bits enter at the
  // MSB as minuend bits leave at the LSB, so after WIDTH steps it holds diff.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    count;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] result;

`ifdef SERIAL_SUB_FLAGS_EN
  // Operand sign bits are shifted out early, so keep them for overflow
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  assign result = {d_bit, a_sh[WIDTH-1:1]};

  // Control FSM plus serial datapath; all outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      count <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= result;
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          br    <= br_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= result;
            bout  <= br_next;
`ifdef SERIAL_SUB_FLAGS_EN
            zero  <= (result == '0);
            neg   <= d_bit;
            ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Brief    : Directed self-checking bench for serial_subtractor (WIDTH=32).
//             Flag outputs are checked when SERIAL_SUB_FLAGS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  wire          busy;
  wire          done;
  wire  [W-1:0] diff;
  wire          bout;
`ifdef SERIAL_SUB_FLAGS_EN
  wire          zero;
  wire          neg;
  wire          ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands and raise start at a falling edge
  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bii);
    @(negedge clk);
    a = ai; b = bi; bin = bii; start = 1'b1;
  endtask

  // Wait (bounded) for done; counts negedges and busy cycles, flags overlap
  task automatic wait_done(input string tag, input bit keep_start,
                           output int cycles, output int busy_cycles);
    int overlap;
    cycles = 0; busy_cycles = 0; overlap = 0;
    do begin
      @(negedge clk);
      if (!keep_start) start = 1'b0;
      cycles++;
      if (busy) busy_cycles++;
      if (busy && done) overlap++;
    end while (!done && cycles < 200);
    check({tag, " done_seen"}, done, 1'b1);
    check({tag, " busy_done_overlap"}, overlap, 0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                              input logic [W-1:0] ed, input logic eb);
    check({tag, " diff"}, diff, ed);
    check({tag, " bout"}, bout, eb);
`ifdef SERIAL_SUB_FLAGS_EN
    check({tag, " zero"}, zero, (ed == '0));
    check({tag, " neg"}, neg, ed[W-1]);
    check({tag, " ovf"}, ovf, (ai[W-1] ^ bi[W-1]) & (ai[W-1] ^ ed[W-1]));
`endif
  endtask

  // One complete operation with latency, busy-length and pulse-width checks
  task automatic op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                    input logic bii, input logic [W-1:0] ed, input logic eb);
    int cyc, bcyc;
    launch(ai, bi, bii);
    wait_done(tag, 1'b0, cyc, bcyc);
    check({tag, " latency"}, cyc, W + 1);
    check({tag, " busy_len"}, bcyc, W);
    check_result(tag, ai, bi, ed, eb);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " diff_held"}, diff, ed);
  endtask

  initial begin
    int cyc, bcyc;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rbin;
    int           seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset diff", diff, '0);
    check("reset bout", bout, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic vectors
    op("t1 10-3",        32'd10,         32'd3, 1'b0, 32'd7,          1'b0);
    op("t2 0-1",         32'd0,          32'd1, 1'b0, 32'hFFFF_FFFF,  1'b1);
    op("t3 min-1",       32'h8000_0000,  32'd1, 1'b0, 32'h7FFF_FFFF,  1'b0);
    op("t3 5-5",         32'd5,          32'd5, 1'b0, 32'd0,          1'b0);
    op("t4 5-5-1",       32'd5,          32'd5, 1'b1, 32'hFFFF_FFFF,  1'b1);
    op("t4 0-0-1",       32'd0,          32'd0, 1'b1, 32'hFFFF_FFFF,  1'b1);
    op("t4 max-0-1",     32'hFFFF_FFFF,  32'd0, 1'b1, 32'hFFFF_FFFE,  1'b0);

    // Start pulsed mid-RUN with new operands must be ignored
    launch(32'd100, 32'd1, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b0;
    a = 32'd7; b = 32'd7; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5 midrun", 1'b0, cyc, bcyc);
    check("t5 midrun latency", cyc, W + 1 - 6);
    check_result("t5 midrun", 32'd100, 32'd1, 32'd99, 1'b0);
    @(negedge clk);

    // Start held high through DONE restarts immediately
    launch(32'd20, 32'd7, 1'b0);
    wait_done("t5 held1", 1'b1, cyc, bcyc);
    check("t5 held1 latency", cyc, W + 1);
    check_result("t5 held1", 32'd20, 32'd7, 32'd13, 1'b0);
    a = 32'd50; b = 32'd8; bin = 1'b0;
    repeat (10) @(negedge clk);
    check("t5 held busy", busy, 1'b1);
    check("t5 held diff_stable", diff, 32'd13);
    start = 1'b0;
    wait_done("t5 held2", 1'b0, cyc, bcyc);
    check("t5 held2 latency", cyc, W + 1 - 10);
    check_result("t5 held2", 32'd50, 32'd8, 32'd42, 1'b0);
    @(negedge clk);

    // Reset asserted mid-RUN aborts with no done pulse
    launch(32'd123, 32'd23, 1'b0);
    repeat (W / 2 + 1) @(negedge clk) start = 1'b0;
    check("t6 busy_before_rst", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6 rst busy", busy, 1'b0);
    check("t6 rst done", done, 1'b0);
    check("t6 rst diff", diff, '0);
    check("t6 rst bout", bout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("t6 no_done_after_abort", seen, 0);
    op("t6 fresh", 32'd123, 32'd23, 1'b0, 32'd100, 1'b0);

    // Randomized operations against a reference model
    for (int i = 0; i < 200; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      op("rand", ra, rb, rbin, full[W-1:0], full[W]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
